// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - decode-stage shared types
package decode_pkg;

    typedef logic [31:0] inst_t;

endpackage

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - fetch-stage shared types and constants
package instruction_fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        decode_pkg::inst_t     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO with flush, count, full and empty
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type T = fetch_entry_t,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  T              wdata_i,
    input  logic          pop_i,
    output T              rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so push+pop is legal even when full.
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !do_pop && !flush_i));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, imem request issue, fetch queue to decode, redirect handling
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     XLEN        = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0000_0000),
    parameter int unsigned     QUEUE_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-1:0]   imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [31:0]       imem_rsp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output decode_pkg::inst_t inst_o,
    output logic [XLEN-1:0]   pc_o
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] SLOTS = (CW + 1)'(QUEUE_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            req_valid;
    logic            req_fire;
    logic            rsp_keep;
    logic [CW:0]     used_slots;

    fetch_entry_t    q_wdata;
    fetch_entry_t    q_head;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;

    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count;
    logic            pcq_full;
    logic            pcq_empty;
    logic            unused_status;

    // Credits cover queued plus in-flight fetches, so a response always has a slot.
    assign used_slots = {1'b0, q_count} + {1'b0, inflight_q};
    assign req_valid  = rst_ni & (state_q == FETCH_RUN) & ~redirect_i & (used_slots < SLOTS);
    assign req_fire   = req_valid & imem_req_ready_i;
    assign rsp_keep   = imem_rsp_valid_i & (state_q == FETCH_RUN) & ~redirect_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;

    assign q_wdata.pc   = pcq_head;
    assign q_wdata.inst = imem_rsp_data_i;

    assign inst_valid_o = ~q_empty & ~redirect_i;
    assign inst_o       = q_head.inst;
    assign pc_o         = q_head.pc;

    assign unused_status = ^{q_full, pcq_count, pcq_full, pcq_empty};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .T     (fetch_entry_t)
    ) u_payload_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (rsp_keep),
        .wdata_i (q_wdata),
        .pop_i   (inst_valid_o & inst_ready_i),
        .rdata_o (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_pc_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_keep),
        .rdata_o (pcq_head),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    // Next-state: PC advance, in-flight tracking, and stale-response drain control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        if (req_fire) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end
        case (state_q)
            FETCH_RUN: begin
                if (redirect_i) begin
                    drop_cnt_d = inflight_q - CW'(imem_rsp_valid_i);
                    if (drop_cnt_d != '0) begin
                        state_d = FETCH_DRAIN;
                    end
                end
            end
            FETCH_DRAIN: begin
                if (imem_rsp_valid_i) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                    if (drop_cnt_q == CW'(1)) begin
                        state_d = FETCH_RUN;
                    end
                end
            end
            default: state_d = FETCH_RUN;
        endcase
        if (redirect_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FETCH_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rsp_valid_i && inflight_q == '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    instruction_fetch #(
        .XLEN        (32),
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          total;
    int          bad;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          stale;
    logic [31:0] exp_addr;
    mreq_t       memq[$];
    ent_t        mq[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        mq.delete();
        stale    = 0;
        exp_addr = RESET_PC;
    endtask

    task automatic tick(input bit redir, input logic [31:0] rpc, input bit iready, input bit mready);
        bit          rsp;
        bit          exp_req;
        bit          exp_iv;
        int          due;
        logic [31:0] raddr;
        rsp   = (memq.size() > 0) && (memq[0].due == cyc);
        raddr = rsp ? memq[0].addr : 32'h0;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        inst_ready_i     = iready;
        imem_req_ready_i = mready;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? memfn(raddr) : $urandom();
        #2;
        exp_req = !redir && (stale == 0) && (mq.size() + memq.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid_o), 32'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr_o, exp_addr);
        exp_iv = !redir && (mq.size() > 0);
        chk("inst_valid", 32'(inst_valid_o), 32'(exp_iv));
        if (exp_iv) begin
            chk("pc_o", pc_o, mq[0].pc);
            chk("inst_o", inst_o, mq[0].inst);
        end
        if (exp_iv && iready) void'(mq.pop_front());
        if (rsp) begin
            void'(memq.pop_front());
            if (stale > 0) stale--;
            else if (!redir) mq.push_back('{raddr, memfn(raddr)});
        end
        if (exp_req && mready) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (memq.size() > 0 && due <= memq[$].due) due = memq[$].due + 1;
            memq.push_back('{due, exp_addr});
            exp_addr = exp_addr + 32'd4;
        end
        if (redir) begin
            mq.delete();
            stale    = memq.size();
            exp_addr = {rpc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        redirect_i       = 1'b0;
        imem_rsp_valid_i = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic rand_tick();
        tick($urandom_range(0, 19) == 0, $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat_min = 1;
        lat_max = 1;
        rst_ni           = 1'b1;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        inst_ready_i     = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        chk("init_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("init_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("init_inst_o", inst_o, 32'd0);
        chk("init_pc_o", pc_o, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // streaming, memory and decode always ready
        repeat (12) tick(1'b0, '0, 1'b1, 1'b1);

        // decode stall, then release
        repeat (8) tick(1'b0, '0, 1'b0, 1'b1);
        repeat (8) tick(1'b0, '0, 1'b1, 1'b1);

        // redirect with two responses in flight at 3-cycle latency
        do_reset();
        lat_min = 3;
        lat_max = 3;
        repeat (2) tick(1'b0, '0, 1'b1, 1'b1);
        tick(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1, 1'b1);

        // redirect coinciding with a response and a decode handshake, unaligned target
        lat_min = 1;
        lat_max = 1;
        repeat (4) tick(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (memq.size() > 0 && memq[0].due == cyc && mq.size() > 0) break;
            tick(1'b0, '0, 1'b1, 1'b1);
        end
        tick(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1, 1'b1);

        // address wrap at the top of the space
        tick(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (8) tick(1'b0, '0, 1'b1, 1'b1);

        // random traffic, reset mid-burst, more random traffic
        lat_min = 1;
        lat_max = 4;
        repeat (300) rand_tick();
        do_reset();
        repeat (150) rand_tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
